// File: rtl/sdram_frame_ctrl_pkg.sv
// Shared types for the SDRAM frame-buffer sequencer: FSM encodings, buffer index
// type and the buffer base-address helper.
package sdram_frame_ctrl_pkg;

  localparam int IDX_W = 2;

  typedef logic [IDX_W-1:0] buf_idx_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_WAIT,
    W_REQ,
    W_NEXT
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_REQ
  } rd_state_e;

  // Computed in 32 bits; callers truncate to the SDRAM address width (modulo wrap).
  function automatic logic [31:0] buf_base(input buf_idx_t idx,
                                           input logic [31:0] base,
                                           input logic [31:0] words);
    return base + (32'(idx) * words);
  endfunction

endpackage

// File: rtl/sdram_frame_ctrl_if.sv
// Camera/SPI/SDRAM-side handshake bundle for sdram_frame_ctrl.
// master = the sequencer, slave = the surrounding FIFOs, decoder and sdram_core.
interface sdram_frame_ctrl_if #(
  parameter int APP_ADDR_WIDTH = 24,
  parameter int FIFO_CNT_WIDTH = 10
);
  logic                      frame_start;
  logic [FIFO_CNT_WIDTH-1:0] wr_fifo_usedw;
  logic                      wr_burst_req;
  logic [APP_ADDR_WIDTH-1:0] wr_burst_addr;
  logic                      wr_burst_finish;
  logic                      rd_start;
  logic                      rd_fifo_full;
  logic                      rd_burst_req;
  logic [APP_ADDR_WIDTH-1:0] rd_burst_addr;
  logic                      rd_burst_finish;
  logic                      frame_ready;
  logic                      rd_busy;
  logic                      rd_reject;
  logic [7:0]                drop_cnt;

  modport master (
    input  frame_start, wr_fifo_usedw, wr_burst_finish,
           rd_start, rd_fifo_full, rd_burst_finish,
    output wr_burst_req, wr_burst_addr, rd_burst_req, rd_burst_addr,
           frame_ready, rd_busy, rd_reject, drop_cnt
  );

  modport slave (
    output frame_start, wr_fifo_usedw, wr_burst_finish,
           rd_start, rd_fifo_full, rd_burst_finish,
    input  wr_burst_req, wr_burst_addr, rd_burst_req, rd_burst_addr,
           frame_ready, rd_busy, rd_reject, drop_cnt
  );
endinterface

// File: rtl/sdram_frame_ctrl_frame_buf_alloc.sv
// Frame buffer bookkeeping: latest published buffer, the readout lock, and
// selection of the next buffer the writer may use.
module frame_buf_alloc
  import sdram_frame_ctrl_pkg::*;
#(
  parameter int NUM_BUFS = 3
) (
  input  logic     clk,
  input  logic     nrst,
  input  logic     i_publish,
  input  buf_idx_t i_pub_idx,
  input  logic     i_lock,
  input  logic     i_unlock,
  output logic     o_latest_valid,
  output buf_idx_t o_rd_idx,
  output logic     o_locked,
  output buf_idx_t o_sel_idx
);

  buf_idx_t r_latest_idx;
  logic     r_latest_valid;
  buf_idx_t r_rd_idx;
  logic     r_locked;

  logic [NUM_BUFS-1:0] w_unlocked;
  logic [NUM_BUFS-1:0] w_free;
  buf_idx_t            w_sel_idx;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BUFS; gi++) begin : g_mask
      assign w_unlocked[gi] = !(r_locked && (r_rd_idx == buf_idx_t'(gi)));
      assign w_free[gi]     = w_unlocked[gi] &&
                              !(r_latest_valid && (r_latest_idx == buf_idx_t'(gi)));
    end
  endgenerate

  // Lowest fully free buffer; with only two buffers fall back to reusing latest.
  always_comb begin
    w_sel_idx = '0;
    for (int i = NUM_BUFS - 1; i >= 0; i--) begin
      if (w_unlocked[i]) w_sel_idx = buf_idx_t'(i);
    end
    if (|w_free) begin
      for (int i = NUM_BUFS - 1; i >= 0; i--) begin
        if (w_free[i]) w_sel_idx = buf_idx_t'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_latest_idx   <= '0;
      r_latest_valid <= 1'b0;
      r_rd_idx       <= '0;
      r_locked       <= 1'b0;
    end else begin
      if (i_publish) begin
        r_latest_idx   <= i_pub_idx;
        r_latest_valid <= 1'b1;
      end
      // Lock captures the pre-publish latest, so a same-cycle publish is not read.
      if (i_lock) begin
        r_rd_idx <= r_latest_idx;
        r_locked <= 1'b1;
      end else if (i_unlock) begin
        r_locked <= 1'b0;
      end
    end
  end

  assign o_latest_valid = r_latest_valid;
  assign o_rd_idx       = r_rd_idx;
  assign o_locked       = r_locked;
  assign o_sel_idx      = w_sel_idx;

endmodule

// File: rtl/sdram_frame_ctrl.sv
// SDRAM frame-buffer sequencer: camera write-burst and SPI read-burst address
// generation over NUM_BUFS rotating frame buffers.
module sdram_frame_ctrl
  import sdram_frame_ctrl_pkg::*;
#(
  parameter int APP_ADDR_WIDTH  = 24,
  parameter int FIFO_CNT_WIDTH  = 10,
  parameter int WR_BURST_LEN    = 256,
  parameter int RD_BURST_LEN    = 1,
  parameter int WORDS_PER_FRAME = 65536,
  parameter int NUM_BUFS        = 3,
  parameter int BASE_ADDR       = 0
) (
  input logic                 clk,
  input logic                 nrst,
  sdram_frame_ctrl_if.master  bus
);

  localparam int OFF_W = $clog2(WORDS_PER_FRAME + 1);
  localparam logic [OFF_W-1:0]          FRAME_END = OFF_W'(WORDS_PER_FRAME);
  localparam logic [OFF_W-1:0]          WR_STEP   = OFF_W'(WR_BURST_LEN);
  localparam logic [OFF_W-1:0]          RD_STEP   = OFF_W'(RD_BURST_LEN);
  localparam logic [31:0]               BASE32    = 32'(BASE_ADDR);
  localparam logic [31:0]               FRAME32   = 32'(WORDS_PER_FRAME);
  localparam logic [APP_ADDR_WIDTH-1:0] ADDR_RST  = APP_ADDR_WIDTH'(BASE_ADDR);
  localparam logic [FIFO_CNT_WIDTH:0]   WATERMARK = (FIFO_CNT_WIDTH + 1)'(WR_BURST_LEN);

  wr_state_e                 r_wr_state;
  buf_idx_t                  r_wr_idx;
  logic [OFF_W-1:0]          r_wr_off;
  logic                      r_wr_req;
  logic [APP_ADDR_WIDTH-1:0] r_wr_addr;
  logic                      r_abort_pend;
  logic [7:0]                r_drop_cnt;

  rd_state_e                 r_rd_state;
  logic [OFF_W-1:0]          r_rd_off;
  logic                      r_rd_req;
  logic [APP_ADDR_WIDTH-1:0] r_rd_addr;
  logic                      r_rd_reject;

  logic                      w_latest_valid;
  buf_idx_t                  w_rd_idx;
  logic                      w_locked;
  buf_idx_t                  w_sel_idx;
  logic                      w_publish;
  logic                      w_rd_lock;
  logic                      w_rd_unlock;
  logic                      w_fifo_ready;
  logic [OFF_W-1:0]          w_rd_off_next;
  logic                      w_rd_last;
  logic [APP_ADDR_WIDTH-1:0] w_wr_addr;
  logic [APP_ADDR_WIDTH-1:0] w_rd_addr;

  assign w_wr_addr     = APP_ADDR_WIDTH'(buf_base(r_wr_idx, BASE32, FRAME32) + 32'(r_wr_off));
  assign w_rd_addr     = APP_ADDR_WIDTH'(buf_base(w_rd_idx, BASE32, FRAME32) + 32'(r_rd_off));
  assign w_fifo_ready  = {1'b0, bus.wr_fifo_usedw} >= WATERMARK;
  assign w_rd_off_next = r_rd_off + RD_STEP;
  assign w_rd_last     = (w_rd_off_next == FRAME_END);

  // A pending or fresh frame_start at W_NEXT wins over publishing the buffer.
  assign w_publish   = (r_wr_state == W_NEXT) && !bus.frame_start && !r_abort_pend &&
                       (r_wr_off == FRAME_END);
  assign w_rd_lock   = (r_rd_state == R_IDLE) && bus.rd_start && w_latest_valid;
  assign w_rd_unlock = (r_rd_state == R_REQ) && bus.rd_burst_finish && w_rd_last;

  frame_buf_alloc #(
    .NUM_BUFS (NUM_BUFS)
  ) u_alloc (
    .clk            (clk),
    .nrst           (nrst),
    .i_publish      (w_publish),
    .i_pub_idx      (r_wr_idx),
    .i_lock         (w_rd_lock),
    .i_unlock       (w_rd_unlock),
    .o_latest_valid (w_latest_valid),
    .o_rd_idx       (w_rd_idx),
    .o_locked       (w_locked),
    .o_sel_idx      (w_sel_idx)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_wr_state   <= W_IDLE;
      r_wr_idx     <= '0;
      r_wr_off     <= '0;
      r_wr_req     <= 1'b0;
      r_wr_addr    <= ADDR_RST;
      r_abort_pend <= 1'b0;
      r_drop_cnt   <= 8'd0;
    end else begin
      case (r_wr_state)
        W_IDLE: begin
          if (bus.frame_start) begin
            r_wr_idx   <= w_sel_idx;
            r_wr_off   <= '0;
            r_wr_state <= W_WAIT;
          end
        end
        W_WAIT: begin
          if (bus.frame_start) begin
            r_wr_idx <= w_sel_idx;
            r_wr_off <= '0;
            if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
          end else if (w_fifo_ready) begin
            r_wr_addr  <= w_wr_addr;
            r_wr_req   <= 1'b1;
            r_wr_state <= W_REQ;
          end
        end
        W_REQ: begin
          // An in-flight burst is never cut short; the abort waits for W_NEXT.
          if (bus.frame_start) r_abort_pend <= 1'b1;
          if (bus.wr_burst_finish) begin
            r_wr_req   <= 1'b0;
            r_wr_off   <= r_wr_off + WR_STEP;
            r_wr_state <= W_NEXT;
          end
        end
        W_NEXT: begin
          if (bus.frame_start || r_abort_pend) begin
            r_wr_idx     <= w_sel_idx;
            r_wr_off     <= '0;
            r_abort_pend <= 1'b0;
            if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
            r_wr_state   <= W_WAIT;
          end else if (r_wr_off == FRAME_END) begin
            r_wr_state <= W_IDLE;
          end else begin
            r_wr_state <= W_WAIT;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_rd_state  <= R_IDLE;
      r_rd_off    <= '0;
      r_rd_req    <= 1'b0;
      r_rd_addr   <= ADDR_RST;
      r_rd_reject <= 1'b0;
    end else begin
      r_rd_reject <= 1'b0;
      case (r_rd_state)
        R_IDLE: begin
          if (bus.rd_start) begin
            if (w_latest_valid) begin
              r_rd_off   <= '0;
              r_rd_state <= R_WAIT;
            end else begin
              r_rd_reject <= 1'b1;
            end
          end
        end
        R_WAIT: begin
          if (bus.rd_start) r_rd_reject <= 1'b1;
          if (!bus.rd_fifo_full) begin
            r_rd_addr  <= w_rd_addr;
            r_rd_req   <= 1'b1;
            r_rd_state <= R_REQ;
          end
        end
        R_REQ: begin
          if (bus.rd_start) r_rd_reject <= 1'b1;
          if (bus.rd_burst_finish) begin
            r_rd_req <= 1'b0;
            if (w_rd_last) begin
              r_rd_state <= R_IDLE;
            end else begin
              r_rd_off   <= w_rd_off_next;
              r_rd_state <= R_WAIT;
            end
          end
        end
        default: r_rd_state <= R_IDLE;
      endcase
    end
  end

  assign bus.wr_burst_req  = r_wr_req;
  assign bus.wr_burst_addr = r_wr_addr;
  assign bus.rd_burst_req  = r_rd_req;
  assign bus.rd_burst_addr = r_rd_addr;
  assign bus.frame_ready   = w_latest_valid;
  assign bus.rd_busy       = w_locked;
  assign bus.rd_reject     = r_rd_reject;
  assign bus.drop_cnt      = r_drop_cnt;

endmodule

// File: tb/tb_sdram_frame_ctrl.sv
// Directed bench for sdram_frame_ctrl with simple sdram_core burst responders.
module tb_sdram_frame_ctrl;

  localparam int AW = 24;
  localparam int FW = 10;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  sdram_frame_ctrl_if #(.APP_ADDR_WIDTH(AW), .FIFO_CNT_WIDTH(FW)) ifc ();

  sdram_frame_ctrl #(
    .APP_ADDR_WIDTH  (AW),
    .FIFO_CNT_WIDTH  (FW),
    .WR_BURST_LEN    (256),
    .RD_BURST_LEN    (1),
    .WORDS_PER_FRAME (1024),
    .NUM_BUFS        (3),
    .BASE_ADDR       (0)
  ) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (ifc.master)
  );

  int          total = 0;
  int          bad   = 0;
  logic [31:0] wr_log[$];
  int          wcnt = 0;
  bit          wdone = 1'b0;
  bit          rdone = 1'b0;
  int          rd_count = 0;
  int          rd_starts = 0;
  int          rd_seq_err = 0;
  int          busy_err = 0;
  logic [31:0] rd_exp_addr = 32'd0;
  int          snap;

  // Write side of sdram_core: finish pulses on the 4th falling edge after req.
  always @(negedge clk) begin : wr_model
    ifc.wr_burst_finish = 1'b0;
    if (nrst !== 1'b1) begin
      wcnt  = 0;
      wdone = 1'b0;
    end else if (ifc.wr_burst_req === 1'b1 && !wdone) begin
      wcnt++;
      if (wcnt == 4) begin
        ifc.wr_burst_finish = 1'b1;
        wr_log.push_back(32'(ifc.wr_burst_addr));
        $display("wr burst addr=%0d", ifc.wr_burst_addr);
        wdone = 1'b1;
        wcnt  = 0;
      end
    end else if (ifc.wr_burst_req !== 1'b1) begin
      wdone = 1'b0;
    end
  end

  // Read side: immediate finish; checks the address sequence as it goes.
  always @(negedge clk) begin : rd_model
    ifc.rd_burst_finish = 1'b0;
    if (nrst !== 1'b1) begin
      rdone = 1'b0;
    end else if (ifc.rd_burst_req === 1'b1 && !rdone) begin
      rd_starts++;
      if (ifc.rd_busy !== 1'b1) busy_err++;
      if (32'(ifc.rd_burst_addr) !== rd_exp_addr) rd_seq_err++;
      rd_exp_addr++;
      rd_count++;
      ifc.rd_burst_finish = 1'b1;
      rdone = 1'b1;
    end else if (ifc.rd_burst_req !== 1'b1) begin
      rdone = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic pulse_frame_start();
    ifc.frame_start = 1'b1;
    tick(1);
    ifc.frame_start = 1'b0;
  endtask

  task automatic pulse_rd_start();
    ifc.rd_start = 1'b1;
    tick(1);
    ifc.rd_start = 1'b0;
  endtask

  task automatic reset_read_model(input logic [31:0] start_addr);
    rd_exp_addr = start_addr;
    rd_count    = 0;
    rd_seq_err  = 0;
  endtask

  initial begin
    nrst              = 1'b0;
    ifc.frame_start   = 1'b0;
    ifc.wr_fifo_usedw = '0;
    ifc.rd_start      = 1'b0;
    ifc.rd_fifo_full  = 1'b0;
    tick(3);

    chk("rst_wr_req",      32'(ifc.wr_burst_req),  0);
    chk("rst_rd_req",      32'(ifc.rd_burst_req),  0);
    chk("rst_frame_ready", 32'(ifc.frame_ready),   0);
    chk("rst_rd_busy",     32'(ifc.rd_busy),       0);
    chk("rst_rd_reject",   32'(ifc.rd_reject),     0);
    chk("rst_drop_cnt",    32'(ifc.drop_cnt),      0);
    chk("rst_wr_addr",     32'(ifc.wr_burst_addr), 0);
    chk("rst_rd_addr",     32'(ifc.rd_burst_addr), 0);

    nrst = 1'b1;
    tick(2);

    // rd_start with nothing published
    pulse_rd_start();
    chk("reject_pulse",    32'(ifc.rd_reject),    1);
    chk("reject_not_busy", 32'(ifc.rd_busy),      0);
    tick(1);
    chk("reject_one_cyc",  32'(ifc.rd_reject),    0);
    chk("reject_no_rdreq", 32'(ifc.rd_burst_req), 0);

    // first frame into buffer 0
    ifc.wr_fifo_usedw = 10'd300;
    wr_log.delete();
    pulse_frame_start();
    for (int k = 0; k < 200 && wr_log.size() < 4; k++) tick(1);
    chk("f1_bursts", 32'(wr_log.size()), 4);
    chk("f1_ready_before_pub", 32'(ifc.frame_ready), 0);
    tick(1);
    chk("f1_ready_after_pub", 32'(ifc.frame_ready), 1);
    for (int i = 0; i < 4; i++) chk($sformatf("f1_addr%0d", i), wr_log[i], 32'(256 * i));

    // full readout of buffer 0
    reset_read_model(32'd0);
    pulse_rd_start();
    chk("rd1_busy", 32'(ifc.rd_busy), 1);
    for (int k = 0; k < 5000 && ifc.rd_busy === 1'b1; k++) tick(1);
    chk("rd1_done_busy", 32'(ifc.rd_busy), 0);
    chk("rd1_count", 32'(rd_count), 1024);
    chk("rd1_seq_err", 32'(rd_seq_err), 0);
    chk("rd_busy_invariant", 32'(busy_err), 0);

    // two frames written while buffer 0 is being read
    reset_read_model(32'd0);
    wr_log.delete();
    pulse_rd_start();
    pulse_frame_start();
    for (int k = 0; k < 200 && wr_log.size() < 4; k++) tick(1);
    tick(2);
    pulse_frame_start();
    for (int k = 0; k < 200 && wr_log.size() < 8; k++) tick(1);
    tick(2);
    chk("rd2_busy_during_wr", 32'(ifc.rd_busy), 1);
    chk("f23_bursts", 32'(wr_log.size()), 8);
    for (int i = 0; i < 8; i++) chk($sformatf("f23_addr%0d", i), wr_log[i], 32'(1024 + 256 * i));
    for (int k = 0; k < 5000 && ifc.rd_busy === 1'b1; k++) tick(1);
    chk("rd2_count", 32'(rd_count), 1024);
    chk("rd2_seq_err", 32'(rd_seq_err), 0);

    // next readout takes the newest buffer (2)
    reset_read_model(32'd2048);
    pulse_rd_start();
    for (int k = 0; k < 5000 && ifc.rd_busy === 1'b1; k++) tick(1);
    chk("rd3_count", 32'(rd_count), 1024);
    chk("rd3_seq_err", 32'(rd_seq_err), 0);
    chk("drop_before_abort", 32'(ifc.drop_cnt), 0);

    // abort after two bursts of a frame into buffer 0
    wr_log.delete();
    pulse_frame_start();
    for (int k = 0; k < 200 && wr_log.size() < 2; k++) tick(1);
    pulse_frame_start();
    chk("abort_drop_cnt", 32'(ifc.drop_cnt), 1);
    chk("abort_ready_kept", 32'(ifc.frame_ready), 1);
    for (int k = 0; k < 200 && wr_log.size() < 3; k++) tick(1);
    chk("abort_addr0", wr_log[0], 32'd0);
    chk("abort_addr1", wr_log[1], 32'd256);
    chk("abort_restart_addr", wr_log[2], 32'd0);

    // latest still buffer 2; stall the read with a full SPI FIFO
    reset_read_model(32'd2048);
    pulse_rd_start();
    for (int k = 0; k < 1000 && rd_count < 100; k++) tick(1);
    ifc.rd_fifo_full = 1'b1;
    tick(3);
    snap = rd_starts;
    tick(47);
    chk("full_no_new_req", 32'(rd_starts), 32'(snap));
    chk("full_req_low", 32'(ifc.rd_burst_req), 0);
    ifc.rd_fifo_full = 1'b0;
    for (int k = 0; k < 1000 && rd_count < 200; k++) tick(1);
    chk("full_resume_count", 32'(rd_count >= 200), 1);
    chk("full_resume_seq", 32'(rd_seq_err), 0);
    chk("restart_frame_bursts", 32'(wr_log.size()), 6);
    chk("restart_frame_last", wr_log[5], 32'd768);
    chk("drop_cnt_held", 32'(ifc.drop_cnt), 1);

    // asynchronous reset in the middle of a write burst and a read
    pulse_frame_start();
    for (int k = 0; k < 50 && ifc.wr_burst_req !== 1'b1; k++) tick(1);
    chk("pre_rst_wr_req", 32'(ifc.wr_burst_req), 1);
    chk("pre_rst_rd_busy", 32'(ifc.rd_busy), 1);
    #2;
    nrst = 1'b0;
    #1;
    chk("arst_wr_req",      32'(ifc.wr_burst_req),  0);
    chk("arst_rd_req",      32'(ifc.rd_burst_req),  0);
    chk("arst_frame_ready", 32'(ifc.frame_ready),   0);
    chk("arst_rd_busy",     32'(ifc.rd_busy),       0);
    chk("arst_rd_reject",   32'(ifc.rd_reject),     0);
    chk("arst_drop_cnt",    32'(ifc.drop_cnt),      0);
    chk("arst_wr_addr",     32'(ifc.wr_burst_addr), 0);
    chk("arst_rd_addr",     32'(ifc.rd_burst_addr), 0);
    tick(2);
    nrst = 1'b1;
    tick(2);
    chk("post_rst_wr_req", 32'(ifc.wr_burst_req), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
